bist_session_ctrl: RTL

// - Sequences one LFSR/MISR logic-BIST session: loads N_SEED seeds into the pattern LFSR,

---
 rtl/bist_session_ctrl_if.sv | 29 ++
 rtl/bist_session_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/bist_session_ctrl_if.sv
// Handshake/status bundle between the logic-BIST session sequencer and the
// top-level START pin plus LFSR/MISR datapath.
interface bist_session_ctrl_if #(
    parameter int SEED_W = 4,
    parameter int SIG_W  = 16
);
    logic              START;
    logic              LFSR_LOAD;
    logic              LFSR_EN;
    logic [SEED_W-1:0] SEED_IDX;
    logic              MISR_CLR;
    logic              MISR_EN;
    logic [SIG_W-1:0]  MISR_SIG;
    logic              RUNNING;
    logic              BIST_END;
    logic              PASS;

    modport master (
        input  START, MISR_SIG,
        output LFSR_LOAD, LFSR_EN, SEED_IDX, MISR_CLR, MISR_EN,
               RUNNING, BIST_END, PASS
    );

    modport slave (
        output START, MISR_SIG,
        input  LFSR_LOAD, LFSR_EN, SEED_IDX, MISR_CLR, MISR_EN,
               RUNNING, BIST_END, PASS
    );
endinterface

// File: rtl/bist_session_ctrl.sv
// Logic-BIST session sequencer: seed loads, pattern runs, final signature check.
// Optional feature macro: BIST_ABORT_EN (dropping START during LOAD/RUN aborts the session).
module bist_session_ctrl #(
    parameter int               N_PAT      = 10,
    parameter int               N_SEED     = 10,
    parameter int               SEED_W     = 4,
    parameter int               SIG_W      = 16,
    parameter logic [SIG_W-1:0] GOLDEN_SIG = 16'hA5C3
) (
    input  logic                CLK,
    input  logic                RESET,
    bist_session_ctrl_if.master bus
);

    // state    | meaning
    // IDLE     | out of reset; waits for START low so a held START cannot launch
    // ARMED    | START seen low; a high START launches a session
    // LOAD     | one cycle: load seed SEED_IDX into the LFSR (MISR clear on seed 0)
    // RUN      | N_PAT cycles of LFSR advance + MISR compaction
    // CHECK    | one cycle: MISR signature compared against GOLDEN_SIG
    // DONE     | BIST_END high, PASS valid; START low re-arms
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam int                PAT_W     = $clog2(N_PAT + 1);
    localparam logic [PAT_W-1:0]  PAT_LAST  = PAT_W'(N_PAT - 1);
    localparam logic [SEED_W-1:0] SEED_LAST = SEED_W'(N_SEED - 1);

    state_t            state_q, state_d;
    logic [SEED_W-1:0] seed_q, seed_d;
    logic [PAT_W-1:0]  pat_cnt_q, pat_cnt_d;
    logic              pass_q, pass_d;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            seed_q    <= '0;
            pat_cnt_q <= '0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            seed_q    <= seed_d;
            pat_cnt_q <= pat_cnt_d;
            pass_q    <= pass_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        seed_d    = seed_q;
        pat_cnt_d = pat_cnt_q;
        pass_d    = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (!bus.START) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (bus.START) begin
                    state_d = ST_LOAD;
                    seed_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                pat_cnt_d = '0;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                // Counter holds at its last value rather than wrapping.
                if (pat_cnt_q == PAT_LAST) begin
                    if (seed_q == SEED_LAST) begin
                        state_d = ST_CHECK;
                    end else begin
                        seed_d  = seed_q + 1'b1;
                        state_d = ST_LOAD;
                    end
                end else begin
                    pat_cnt_d = pat_cnt_q + 1'b1;
                end
            end
            ST_CHECK: begin
                pass_d  = (bus.MISR_SIG == GOLDEN_SIG);
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!bus.START) state_d = ST_ARMED;
            end
            default: begin
                state_d   = ST_IDLE;
                seed_d    = '0;
                pat_cnt_d = '0;
                pass_d    = 1'b0;
            end
        endcase
`ifdef BIST_ABORT_EN
        if ((state_q == ST_LOAD || state_q == ST_RUN) && !bus.START) begin
            state_d   = ST_ARMED;
            seed_d    = '0;
            pat_cnt_d = '0;
            pass_d    = 1'b0;
        end
`endif
    end

    logic lfsr_load, run_en, misr_clr, running, bist_end;

    always_comb begin
        lfsr_load = 1'b0;
        run_en    = 1'b0;
        misr_clr  = 1'b0;
        running   = 1'b0;
        bist_end  = 1'b0;
        case (state_q)
            ST_LOAD: begin
                lfsr_load = 1'b1;
                misr_clr  = (seed_q == '0);
                running   = 1'b1;
            end
            ST_RUN: begin
                run_en  = 1'b1;
                running = 1'b1;
            end
            ST_DONE: bist_end = 1'b1;
            default: ;
        endcase
    end

    assign bus.LFSR_LOAD = lfsr_load;
    assign bus.LFSR_EN   = run_en;
    assign bus.MISR_EN   = run_en;
    assign bus.MISR_CLR  = misr_clr;
    assign bus.RUNNING   = running;
    assign bus.BIST_END  = bist_end;
    assign bus.SEED_IDX  = seed_q;
    assign bus.PASS      = pass_q;

endmodule
